// File: rtl/wb_vmemem_bridge_if.sv
// Bus bundle between a Wishbone classic host and the VME-style strobe/done
// register-bank slave, as seen by wb_vmemem_bridge.
//   slave  modport : the bridge's view (WB slave + memory-side master)
//   master modport : the host/slave-model view (drives WB requests and
//                    memory-side done/data)
// Signals:
//   wb_*  : Wishbone classic single transfer (cyc/stb/we/adr/sel/dat, ack/err)
//   mem_* : word address, write data, rd/wr strobes, rd data, dones, errors
interface wb_vmemem_bridge_if #(
   parameter int ADDR_W = 20
);
   logic              wb_cyc_i;
   logic              wb_stb_i;
   logic              wb_we_i;
   logic [ADDR_W-1:0] wb_adr_i;
   logic [3:0]        wb_sel_i;
   logic [31:0]       wb_dat_i;
   logic [31:0]       wb_dat_o;
   logic              wb_ack_o;
   logic              wb_err_o;

   logic [ADDR_W-3:0] mem_addr_o;
   logic [31:0]       mem_wr_data_o;
   logic              mem_rd_o;
   logic              mem_wr_o;
   logic [31:0]       mem_rd_data_i;
   logic              mem_rd_done_i;
   logic              mem_wr_done_i;
   logic              mem_rd_error_i;
   logic              mem_wr_error_i;

   modport slave (
      input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
      output wb_dat_o, wb_ack_o, wb_err_o,
      output mem_addr_o, mem_wr_data_o, mem_rd_o, mem_wr_o,
      input  mem_rd_data_i, mem_rd_done_i, mem_wr_done_i,
      input  mem_rd_error_i, mem_wr_error_i
   );

   modport master (
      output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
      input  wb_dat_o, wb_ack_o, wb_err_o,
      input  mem_addr_o, mem_wr_data_o, mem_rd_o, mem_wr_o,
      output mem_rd_data_i, mem_rd_done_i, mem_wr_done_i,
      output mem_rd_error_i, mem_wr_error_i
   );
endinterface

// File: rtl/wb_vmemem_bridge.sv
// Wishbone classic -> VME-style strobe/done bridge. Each accepted WB single
// transfer becomes one single-cycle mem_rd_o/mem_wr_o strobe; the bridge then
// waits for the matching done and answers with a 1-cycle ack, or err on slave
// error, timeout, or a write with partial byte selects. One transfer in flight.
// Ports:
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : wb_vmemem_bridge_if.slave (WB slave side + memory master side)
// All outputs are registered.
module wb_vmemem_bridge #(
   parameter int ADDR_W  = 20,
   parameter int TIMEOUT = 255
) (
   input  logic                 clk,
   input  logic                 rst_n,
   wb_vmemem_bridge_if.slave    bus
);

   typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, RESP} state_t;

   state_t            state_q, state_d;
   logic [15:0]       cnt_q, cnt_d;
   logic              abort_q, abort_d;
   logic              ack_q, ack_d;
   logic              err_q, err_d;
   logic              rd_q, rd_d;
   logic              wr_q, wr_d;
   logic [ADDR_W-3:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       rdata_q, rdata_d;

   // Only the done/error pair matching the pending direction is looked at.
   logic wait_done, wait_err, aborted;
   assign wait_done = (state_q == RD_WAIT) ? bus.mem_rd_done_i  : bus.mem_wr_done_i;
   assign wait_err  = (state_q == RD_WAIT) ? bus.mem_rd_error_i : bus.mem_wr_error_i;
   // Host dropping cyc at any point of the wait kills the response.
   assign aborted   = abort_q | ~bus.wb_cyc_i;

   // Byte lanes of the address are meaningless to a word-addressed slave.
   logic unused_adr_lsb;
   assign unused_adr_lsb = ^bus.wb_adr_i[1:0];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         abort_q <= 1'b0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         abort_q <= abort_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      abort_d = abort_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      ack_d   = 1'b0;
      err_d   = 1'b0;
      rd_d    = 1'b0;
      wr_d    = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.wb_cyc_i && bus.wb_stb_i) begin
               addr_d  = bus.wb_adr_i[ADDR_W-1:2];
               wdata_d = bus.wb_dat_i;
               cnt_d   = '0;
               abort_d = 1'b0;
               if (bus.wb_we_i && bus.wb_sel_i != 4'hF) begin
                  // Partial writes are not supported by the slave: refuse
                  // without touching it.
                  err_d   = 1'b1;
                  state_d = RESP;
               end else if (bus.wb_we_i) begin
                  wr_d    = 1'b1;
                  state_d = WR_WAIT;
               end else begin
                  rd_d    = 1'b1;
                  state_d = RD_WAIT;
               end
            end
         end

         RD_WAIT, WR_WAIT: begin
            abort_d = aborted;
            if (state_q == RD_WAIT && bus.mem_rd_done_i)
               rdata_d = bus.mem_rd_data_i;
            // Done is checked before expiry so a done on the last allowed
            // cycle still completes normally.
            if (wait_done) begin
               if (aborted) begin
                  state_d = IDLE;
               end else begin
                  ack_d   = ~wait_err;
                  err_d   = wait_err;
                  state_d = RESP;
               end
            end else if (cnt_q == 16'(TIMEOUT)) begin
               if (aborted) begin
                  state_d = IDLE;
               end else begin
                  err_d   = 1'b1;
                  state_d = RESP;
               end
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end

         RESP: begin
            // Pulse cycle; stb is deliberately not sampled here.
            state_d = IDLE;
         end

         default: state_d = IDLE;
      endcase
   end

   assign bus.wb_ack_o      = ack_q;
   assign bus.wb_err_o      = err_q;
   assign bus.wb_dat_o      = rdata_q;
   assign bus.mem_rd_o      = rd_q;
   assign bus.mem_wr_o      = wr_q;
   assign bus.mem_addr_o    = addr_q;
   assign bus.mem_wr_data_o = wdata_q;

endmodule

// File: tb/tb_wb_vmemem_bridge.sv
// Directed bench for wb_vmemem_bridge (TIMEOUT=4). Inputs are driven and
// outputs sampled 1 time unit after each rising edge.
module tb_wb_vmemem_bridge;

   localparam int ADDR_W  = 20;
   localparam int TIMEOUT = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_chk = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   wb_vmemem_bridge_if #(.ADDR_W(ADDR_W)) bus ();

   wb_vmemem_bridge #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wb_req(input logic we, input logic [ADDR_W-1:0] adr,
                         input logic [3:0] sel, input logic [31:0] dat);
      bus.wb_cyc_i = 1'b1;
      bus.wb_stb_i = 1'b1;
      bus.wb_we_i  = we;
      bus.wb_adr_i = adr;
      bus.wb_sel_i = sel;
      bus.wb_dat_i = dat;
   endtask

   task automatic wb_drop();
      bus.wb_cyc_i = 1'b0;
      bus.wb_stb_i = 1'b0;
   endtask

   task automatic mem_clear();
      bus.mem_rd_done_i  = 1'b0;
      bus.mem_wr_done_i  = 1'b0;
      bus.mem_rd_error_i = 1'b0;
      bus.mem_wr_error_i = 1'b0;
   endtask

   initial begin
      wb_drop();
      bus.wb_we_i = 1'b0;
      bus.wb_adr_i = '0;
      bus.wb_sel_i = 4'h0;
      bus.wb_dat_i = '0;
      bus.mem_rd_data_i = '0;
      mem_clear();

      // Reset state
      tick(); tick();
      chk("rst_ack",   {31'b0, bus.wb_ack_o}, 32'd0);
      chk("rst_err",   {31'b0, bus.wb_err_o}, 32'd0);
      chk("rst_rd",    {31'b0, bus.mem_rd_o}, 32'd0);
      chk("rst_wr",    {31'b0, bus.mem_wr_o}, 32'd0);
      chk("rst_addr",  32'(bus.mem_addr_o), 32'd0);
      chk("rst_dat",   bus.wb_dat_o, 32'd0);
      rst_n = 1'b1;
      tick();

      // Read 0x4, done 1 cycle after strobe
      wb_req(1'b0, 20'h4, 4'hF, 32'h0);
      tick();                                   // cycle 1
      chk("rd_strobe", {31'b0, bus.mem_rd_o}, 32'd1);
      chk("rd_addr",   32'(bus.mem_addr_o), 32'd1);
      chk("rd_no_wr",  {31'b0, bus.mem_wr_o}, 32'd0);
      tick();                                   // cycle 2
      chk("rd_strobe_1cyc", {31'b0, bus.mem_rd_o}, 32'd0);
      bus.mem_rd_done_i = 1'b1;
      bus.mem_rd_data_i = 32'h0000BEEF;
      tick();                                   // cycle 3
      mem_clear();
      chk("rd_ack",    {31'b0, bus.wb_ack_o}, 32'd1);
      chk("rd_err",    {31'b0, bus.wb_err_o}, 32'd0);
      chk("rd_data",   bus.wb_dat_o, 32'h0000BEEF);
      wb_drop();
      tick();
      chk("rd_ack_1cyc", {31'b0, bus.wb_ack_o}, 32'd0);

      // Write 0x0 data 0xA5, wr_done 2 cycles after strobe
      wb_req(1'b1, 20'h0, 4'hF, 32'h000000A5);
      tick();                                   // cycle 1
      chk("wr_strobe", {31'b0, bus.mem_wr_o}, 32'd1);
      chk("wr_no_rd",  {31'b0, bus.mem_rd_o}, 32'd0);
      chk("wr_data",   bus.mem_wr_data_o, 32'h000000A5);
      chk("wr_addr",   32'(bus.mem_addr_o), 32'd0);
      tick();                                   // cycle 2
      chk("wr_strobe_1cyc", {31'b0, bus.mem_wr_o}, 32'd0);
      tick();                                   // cycle 3
      bus.mem_wr_done_i = 1'b1;
      tick();                                   // cycle 4
      mem_clear();
      chk("wr_ack",    {31'b0, bus.wb_ack_o}, 32'd1);
      chk("wr_err",    {31'b0, bus.wb_err_o}, 32'd0);
      wb_drop();
      tick();
      chk("wr_ack_1cyc", {31'b0, bus.wb_ack_o}, 32'd0);
      chk("wr_data_hold", bus.mem_wr_data_o, 32'h000000A5);

      // Write with sel=3: refused without strobe
      wb_req(1'b1, 20'h8, 4'h3, 32'h11111111);
      tick();
      chk("sel_no_wr", {31'b0, bus.mem_wr_o}, 32'd0);
      chk("sel_err",   {31'b0, bus.wb_err_o}, 32'd1);
      chk("sel_ack",   {31'b0, bus.wb_ack_o}, 32'd0);
      wb_drop();
      tick();
      chk("sel_err_1cyc", {31'b0, bus.wb_err_o}, 32'd0);

      // Timeout: silent slave, err 5 cycles after strobe cycle
      wb_req(1'b0, 20'h10, 4'hF, 32'h0);
      tick();                                   // cycle 1 (strobe)
      chk("to_strobe", {31'b0, bus.mem_rd_o}, 32'd1);
      tick(); tick(); tick(); tick();           // cycle 5
      chk("to_not_early", {31'b0, bus.wb_err_o}, 32'd0);
      tick();                                   // cycle 6
      chk("to_err",    {31'b0, bus.wb_err_o}, 32'd1);
      chk("to_ack",    {31'b0, bus.wb_ack_o}, 32'd0);
      wb_drop();
      tick();
      chk("to_err_1cyc", {31'b0, bus.wb_err_o}, 32'd0);
      bus.mem_rd_done_i = 1'b1;                 // late done
      bus.mem_rd_data_i = 32'hCAFE0000;
      tick();
      chk("late_no_ack", {31'b0, bus.wb_ack_o}, 32'd0);
      mem_clear();
      tick();
      chk("late_no_ack2", {31'b0, bus.wb_ack_o}, 32'd0);
      chk("late_dat_hold", bus.wb_dat_o, 32'h0000BEEF);

      // Done in the expiry cycle wins
      wb_req(1'b0, 20'h14, 4'hF, 32'h0);
      tick(); tick(); tick(); tick();           // cycle 4
      tick();                                   // cycle 5
      bus.mem_rd_done_i = 1'b1;
      bus.mem_rd_data_i = 32'h00C0FFEE;
      tick();                                   // cycle 6
      mem_clear();
      chk("edge_ack",  {31'b0, bus.wb_ack_o}, 32'd1);
      chk("edge_err",  {31'b0, bus.wb_err_o}, 32'd0);
      chk("edge_data", bus.wb_dat_o, 32'h00C0FFEE);
      wb_drop();
      tick();

      // Read with slave error, done in the strobe cycle
      wb_req(1'b0, 20'h8, 4'hF, 32'h0);
      tick();                                   // cycle 1
      bus.mem_rd_done_i  = 1'b1;
      bus.mem_rd_error_i = 1'b1;
      bus.mem_rd_data_i  = 32'h00001234;
      tick();                                   // cycle 2
      mem_clear();
      chk("rderr_err", {31'b0, bus.wb_err_o}, 32'd1);
      chk("rderr_ack", {31'b0, bus.wb_ack_o}, 32'd0);
      wb_drop();
      tick();
      chk("rderr_1cyc", {31'b0, bus.wb_err_o}, 32'd0);

      // Abort: cyc dropped in RD_WAIT
      wb_req(1'b0, 20'hC, 4'hF, 32'h0);
      tick();                                   // cycle 1
      wb_drop();
      tick();                                   // cycle 2
      bus.mem_rd_done_i = 1'b1;
      bus.mem_rd_data_i = 32'h55555555;
      tick();                                   // cycle 3
      mem_clear();
      chk("abort_ack", {31'b0, bus.wb_ack_o}, 32'd0);
      chk("abort_err", {31'b0, bus.wb_err_o}, 32'd0);
      // Bridge must be idle again: a fresh read completes normally
      wb_req(1'b0, 20'h18, 4'hF, 32'h0);
      tick();                                   // cycle 1
      chk("post_abort_strobe", {31'b0, bus.mem_rd_o}, 32'd1);
      chk("post_abort_addr",   32'(bus.mem_addr_o), 32'd6);
      bus.mem_rd_done_i = 1'b1;
      bus.mem_rd_data_i = 32'h0BADF00D;
      tick();                                   // cycle 2
      mem_clear();
      chk("post_abort_ack",  {31'b0, bus.wb_ack_o}, 32'd1);
      chk("post_abort_data", bus.wb_dat_o, 32'h0BADF00D);
      wb_drop();
      tick();

      // Reset in WR_WAIT
      wb_req(1'b1, 20'h20, 4'hF, 32'hDEADDEAD);
      tick();                                   // cycle 1
      chk("rw_strobe", {31'b0, bus.mem_wr_o}, 32'd1);
      chk("rw_addr",   32'(bus.mem_addr_o), 32'd8);
      rst_n = 1'b0;
      tick();
      chk("rw_wr0",    {31'b0, bus.mem_wr_o}, 32'd0);
      chk("rw_addr0",  32'(bus.mem_addr_o), 32'd0);
      chk("rw_wdata0", bus.mem_wr_data_o, 32'd0);
      chk("rw_dat0",   bus.wb_dat_o, 32'd0);
      rst_n = 1'b1;
      wb_drop();
      bus.mem_wr_done_i = 1'b1;
      tick();
      mem_clear();
      chk("rw_no_ack", {31'b0, bus.wb_ack_o}, 32'd0);
      chk("rw_no_err", {31'b0, bus.wb_err_o}, 32'd0);
      tick();
      chk("rw_no_ack2", {31'b0, bus.wb_ack_o}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
